// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out stream serializer:
// FSM state encoding and the beat/counter sizing helpers used by the top.
package piso_pkg;

  // Serializer state: no word loaded, or a word being shifted out.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  // Number of LANES-wide beats needed to emit one DATA_WIDTH word.
  function automatic int beats(input int data_width, input int lanes);
    return (lanes > 0) ? (data_width / lanes) : 1;
  endfunction

  // Beat counter width; a single-beat word still gets a 1-bit counter.
  function automatic int cnt_width(input int n_beats);
    return (n_beats <= 1) ? 1 : $clog2(n_beats);
  endfunction

endpackage

// File: rtl/piso_hold_reg.sv
// One-entry valid/data holding register. A word is written with load and
// released with take; the serializer uses it to prefetch the next word while
// the current one is still shifting.
module piso_hold_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  take,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  // Occupancy flag: load sets it, take clears it (load wins if both).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

  // Payload capture.
  // NOTE: the payload has no reset; valid alone qualifies it, so clearing
  // the data bits on reset would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (load) begin
      data <= load_data;
    end
  end

endmodule

// File: rtl/piso_stream_serializer.sv
// Parallel-in/serial-out stream serializer. Accepts DATA_WIDTH-bit words on a
// valid/ready handshake and emits LANES-bit beats, LSB-first or MSB-first,
// with downstream backpressure and first/last beat markers.
//
// Optional feature: define PISO_PREFETCH_EN to add a one-word holding
// register, allowing gapless back-to-back words. Without it, one idle cycle
// separates consecutive words.
module piso_stream_serializer
  import piso_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 1,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [LANES-1:0]      dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_first,
  output logic                  dout_last,
  output logic                  busy
);

  localparam int              BEATS     = beats(DATA_WIDTH, LANES);
  localparam int              CW        = cnt_width(BEATS);
  localparam logic [CW-1:0]   LAST_BEAT = CW'(BEATS - 1);

  // Elaboration-time parameter legality checks.
  if (LANES < 1 || LANES > DATA_WIDTH) begin : g_bad_lanes
    $error("piso_stream_serializer: LANES (%0d) must be in 1..DATA_WIDTH (%0d)",
           LANES, DATA_WIDTH);
  end
  if (LANES >= 1) begin : g_div_check
    if (DATA_WIDTH % LANES != 0) begin : g_bad_div
      $error("piso_stream_serializer: DATA_WIDTH (%0d) not a multiple of LANES (%0d)",
             DATA_WIDTH, LANES);
    end
  end
  if (MSB_FIRST != 0 && MSB_FIRST != 1) begin : g_bad_order
    $error("piso_stream_serializer: MSB_FIRST must be 0 or 1");
  end

  piso_state_e           state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] shift_reg_adv;
  logic [CW-1:0]         cnt;

  logic                  in_shift;
  logic                  accept;
  logic                  retire;
  logic                  last_beat;
  logic                  load_word;
  logic [DATA_WIDTH-1:0] load_data;

  assign in_shift  = (state == SHIFT);
  assign accept    = din_valid & din_ready;
  assign retire    = in_shift & dout_ready;
  assign last_beat = (cnt == LAST_BEAT);

  // Output lane selection and the matching zero-fill shift direction.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign dout          = shift_reg[DATA_WIDTH-1 -: LANES];
    assign shift_reg_adv = shift_reg << LANES;
  end else begin : g_lsb_first
    assign dout          = shift_reg[LANES-1:0];
    assign shift_reg_adv = shift_reg >> LANES;
  end

  assign dout_valid = in_shift;
  assign dout_first = in_shift & (cnt == '0);
  assign dout_last  = in_shift & last_beat;

`ifdef PISO_PREFETCH_EN
  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_load;
  logic                  hold_take;

  // Ready whenever the holding slot is free; held low during reset.
  assign din_ready = ~hold_valid & ~reset;
  assign busy      = in_shift | hold_valid;

  // An accept while shifting is parked, unless the last beat retires at the
  // same edge with nothing held, in which case it goes straight to the shifter.
  assign hold_load = accept & in_shift & ~(retire & last_beat);
  assign hold_take = retire & last_beat & hold_valid;

  piso_hold_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (hold_load),
    .load_data (din),
    .take      (hold_take),
    .valid     (hold_valid),
    .data      (hold_data)
  );
`else
  // Only an idle serializer takes a new word; held low during reset.
  assign din_ready = ~in_shift & ~reset;
  assign busy      = in_shift;
`endif

  // Decide whether the shift register loads a fresh word this edge.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    load_word = 1'b0;
    load_data = din;
    if (!in_shift) begin
      load_word = accept;
    end
`ifdef PISO_PREFETCH_EN
    if (in_shift && retire && last_beat && (hold_valid || accept)) begin
      load_word = 1'b1;
      load_data = hold_valid ? hold_data : din;
    end
`endif
  end

  // Serializer FSM, shift register and beat counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
    end else if (load_word) begin
      state     <= SHIFT;
      shift_reg <= load_data;
      cnt       <= '0;
    end else if (retire) begin
      if (last_beat) begin
        state <= IDLE;
      end else begin
        shift_reg <= shift_reg_adv;
        cnt       <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_piso_stream_serializer.sv
// Directed testbench for piso_stream_serializer. Four instances cover the
// LSB-first/MSB-first 4-lane, 1-lane and single-beat (LANES=DATA_WIDTH)
// configurations. Expectations adapt to PISO_PREFETCH_EN when it is defined.
module tb_piso_stream_serializer;

`ifdef PISO_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 16-bit, 4 lanes, LSB first
  logic [15:0] lsb_din;
  logic        lsb_din_valid, lsb_din_ready;
  logic [3:0]  lsb_dout;
  logic        lsb_dout_valid, lsb_dout_ready, lsb_dout_first, lsb_dout_last, lsb_busy;
  // 16-bit, 4 lanes, MSB first
  logic [15:0] msb_din;
  logic        msb_din_valid, msb_din_ready;
  logic [3:0]  msb_dout;
  logic        msb_dout_valid, msb_dout_ready, msb_dout_first, msb_dout_last, msb_busy;
  // 16-bit, 1 lane, LSB first
  logic [15:0] bit_din;
  logic        bit_din_valid, bit_din_ready;
  logic [0:0]  bit_dout;
  logic        bit_dout_valid, bit_dout_ready, bit_dout_first, bit_dout_last, bit_busy;
  // 8-bit, 8 lanes (single beat)
  logic [7:0]  byt_din;
  logic        byt_din_valid, byt_din_ready;
  logic [7:0]  byt_dout;
  logic        byt_dout_valid, byt_dout_ready, byt_dout_first, byt_dout_last, byt_busy;

  piso_stream_serializer #(.DATA_WIDTH(16), .LANES(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .din(lsb_din), .din_valid(lsb_din_valid),
    .din_ready(lsb_din_ready), .dout(lsb_dout), .dout_valid(lsb_dout_valid),
    .dout_ready(lsb_dout_ready), .dout_first(lsb_dout_first),
    .dout_last(lsb_dout_last), .busy(lsb_busy));

  piso_stream_serializer #(.DATA_WIDTH(16), .LANES(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .din(msb_din), .din_valid(msb_din_valid),
    .din_ready(msb_din_ready), .dout(msb_dout), .dout_valid(msb_dout_valid),
    .dout_ready(msb_dout_ready), .dout_first(msb_dout_first),
    .dout_last(msb_dout_last), .busy(msb_busy));

  piso_stream_serializer #(.DATA_WIDTH(16), .LANES(1), .MSB_FIRST(0)) u_bit (
    .clk(clk), .reset(reset), .din(bit_din), .din_valid(bit_din_valid),
    .din_ready(bit_din_ready), .dout(bit_dout), .dout_valid(bit_dout_valid),
    .dout_ready(bit_dout_ready), .dout_first(bit_dout_first),
    .dout_last(bit_dout_last), .busy(bit_busy));

  piso_stream_serializer #(.DATA_WIDTH(8), .LANES(8), .MSB_FIRST(0)) u_byt (
    .clk(clk), .reset(reset), .din(byt_din), .din_valid(byt_din_valid),
    .din_ready(byt_din_ready), .dout(byt_dout), .dout_valid(byt_dout_valid),
    .dout_ready(byt_dout_ready), .dout_first(byt_dout_first),
    .dout_last(byt_dout_last), .busy(byt_busy));

  // Advance one clock; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    lsb_din = '0; lsb_din_valid = 1'b0; lsb_dout_ready = 1'b0;
    msb_din = '0; msb_din_valid = 1'b0; msb_dout_ready = 1'b0;
    bit_din = '0; bit_din_valid = 1'b0; bit_dout_ready = 1'b0;
    byt_din = '0; byt_din_valid = 1'b0; byt_dout_ready = 1'b0;
    #2;
    n_checks++;
    if ({lsb_din_ready, lsb_dout_valid, lsb_dout_first, lsb_dout_last, lsb_busy, lsb_dout} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_lsb: got %b expected all zero",
               {lsb_din_ready, lsb_dout_valid, lsb_dout_first, lsb_dout_last, lsb_busy, lsb_dout});
    end
    n_checks++;
    if ({msb_din_ready, msb_dout_valid, msb_dout_first, msb_dout_last, msb_busy, msb_dout} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_msb: got %b expected all zero",
               {msb_din_ready, msb_dout_valid, msb_dout_first, msb_dout_last, msb_busy, msb_dout});
    end
    n_checks++;
    if ({bit_din_ready, bit_dout_valid, bit_dout_first, bit_dout_last, bit_busy, bit_dout} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_bit: got %b expected all zero",
               {bit_din_ready, bit_dout_valid, bit_dout_first, bit_dout_last, bit_busy, bit_dout});
    end
    n_checks++;
    if ({byt_din_ready, byt_dout_valid, byt_dout_first, byt_dout_last, byt_busy, byt_dout} !== 13'b0) begin
      n_fail++;
      $display("FAIL reset_byt: got %b expected all zero",
               {byt_din_ready, byt_dout_valid, byt_dout_first, byt_dout_last, byt_busy, byt_dout});
    end
    step();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({lsb_din_ready, msb_din_ready, bit_din_ready, byt_din_ready,
         lsb_busy, msb_busy, bit_busy, byt_busy} !== 8'hF0) begin
      n_fail++;
      $display("FAIL reset_release: got ready/busy %b expected 11110000",
               {lsb_din_ready, msb_din_ready, bit_din_ready, byt_din_ready,
                lsb_busy, msb_busy, bit_busy, byt_busy});
    end
    step();
  endtask

  task automatic test_lsb_first();
    logic [3:0] exp_beats [4];
    exp_beats = '{4'h3, 4'hC, 4'h5, 4'hA};
    lsb_dout_ready = 1'b1;
    lsb_din = 16'hA5C3; lsb_din_valid = 1'b1;
    step();
    lsb_din_valid = 1'b0; lsb_din = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({lsb_dout_valid, lsb_dout, lsb_dout_first, lsb_dout_last} !==
          {1'b1, exp_beats[i], (i == 0), (i == 3)}) begin
        n_fail++;
        $display("FAIL lsb_beat%0d: got v/d/f/l %b expected %b", i,
                 {lsb_dout_valid, lsb_dout, lsb_dout_first, lsb_dout_last},
                 {1'b1, exp_beats[i], (i == 0), (i == 3)});
      end
      if (i == 1) begin
        n_checks++;
        if ({lsb_busy, lsb_din_ready} !== {1'b1, PF}) begin
          n_fail++;
          $display("FAIL lsb_busy_mid: got busy/ready %b expected %b",
                   {lsb_busy, lsb_din_ready}, {1'b1, PF});
        end
      end
      step();
    end
    n_checks++;
    if ({lsb_dout_valid, lsb_busy, lsb_din_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL lsb_end_idle: got valid/busy/ready %b expected 001",
               {lsb_dout_valid, lsb_busy, lsb_din_ready});
    end
  endtask

  task automatic test_msb_first();
    logic [3:0] exp_beats [4];
    exp_beats = '{4'hA, 4'h5, 4'hC, 4'h3};
    msb_dout_ready = 1'b1;
    msb_din = 16'hA5C3; msb_din_valid = 1'b1;
    step();
    msb_din_valid = 1'b0; msb_din = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({msb_dout_valid, msb_dout, msb_dout_first, msb_dout_last} !==
          {1'b1, exp_beats[i], (i == 0), (i == 3)}) begin
        n_fail++;
        $display("FAIL msb_beat%0d: got v/d/f/l %b expected %b", i,
                 {msb_dout_valid, msb_dout, msb_dout_first, msb_dout_last},
                 {1'b1, exp_beats[i], (i == 0), (i == 3)});
      end
      step();
    end
    n_checks++;
    if ({msb_dout_valid, msb_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL msb_end_idle: got valid/busy %b expected 00", {msb_dout_valid, msb_busy});
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] cap;
    logic [6:0]  prev;
    bit          prev_stall;
    int          got;
    cap = '0; prev = '0; prev_stall = 1'b0; got = 0;
    lsb_dout_ready = 1'b0;
    lsb_din = 16'h1234; lsb_din_valid = 1'b1;
    step();
    lsb_din_valid = 1'b0; lsb_din = 16'hDEAD;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      lsb_dout_ready = ((cyc % 3) == 0);
      if (prev_stall) begin
        n_checks++;
        if ({lsb_dout_valid, lsb_dout, lsb_dout_first, lsb_dout_last} !== prev) begin
          n_fail++;
          $display("FAIL bp_stall_hold cycle %0d: got %b expected %b", cyc,
                   {lsb_dout_valid, lsb_dout, lsb_dout_first, lsb_dout_last}, prev);
        end
      end
      if (lsb_dout_valid && lsb_dout_ready) begin
        cap[got*4 +: 4] = lsb_dout;
        got++;
      end
      prev_stall = lsb_dout_valid & ~lsb_dout_ready;
      prev       = {lsb_dout_valid, lsb_dout, lsb_dout_first, lsb_dout_last};
      step();
    end
    lsb_dout_ready = 1'b1;
    n_checks++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL bp_beat_count: got %0d expected 4", got);
    end
    n_checks++;
    if (cap !== 16'h1234) begin
      n_fail++;
      $display("FAIL bp_order: got beats (low nibble first) %h expected 1234", cap);
    end
    n_checks++;
    if (lsb_dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_duplicate: got dout_valid %b expected 0", lsb_dout_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] cap;
    int          acc, n, gaps, low;
    bit          will;
    cap = '0; acc = 0; n = 0; gaps = 0; low = 0;
    bit_dout_ready = 1'b1;
    bit_din = 16'h0001; bit_din_valid = 1'b1;
    for (int cyc = 0; cyc < 80 && n < 32; cyc++) begin
      if (bit_dout_valid) begin
        cap[n] = bit_dout[0];
        n++;
      end else if (n > 0) begin
        gaps++;
      end
      if (!bit_din_ready) low++;
      will = bit_din_valid & bit_din_ready;
      step();
      if (will) begin
        acc++;
        if (acc == 1) bit_din = 16'h8000;
        else          bit_din_valid = 1'b0;
      end
    end
    bit_din_valid = 1'b0;
    n_checks++;
    if (n != 32 || acc != 2) begin
      n_fail++;
      $display("FAIL b2b_counts: got beats %0d accepts %0d expected 32 and 2", n, acc);
    end
    n_checks++;
    if (cap !== 32'h8000_0001) begin
      n_fail++;
      $display("FAIL b2b_stream: got %h expected 80000001", cap);
    end
    n_checks++;
    if (gaps != (PF ? 0 : 1)) begin
      n_fail++;
      $display("FAIL b2b_bubbles: got %0d expected %0d", gaps, (PF ? 0 : 1));
    end
    n_checks++;
    if (low != (PF ? 15 : 32)) begin
      n_fail++;
      $display("FAIL b2b_ready_low_cycles: got %0d expected %0d", low, (PF ? 15 : 32));
    end
  endtask

  task automatic test_mid_word_reset();
    logic [3:0] exp_beats [4];
    exp_beats = '{4'hD, 4'hC, 4'hB, 4'hA};
    lsb_dout_ready = 1'b1;
    lsb_din = 16'h1234; lsb_din_valid = 1'b1;
    step();
    lsb_din_valid = 1'b0;
    step();
    step();
    n_checks++;
    if ({lsb_dout_valid, lsb_dout} !== 5'b1_0010) begin
      n_fail++;
      $display("FAIL rst_pre_beat2: got v/d %b expected 10010", {lsb_dout_valid, lsb_dout});
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({lsb_dout_valid, lsb_busy, lsb_dout, lsb_dout_first, lsb_dout_last, lsb_din_ready} !== 9'b0) begin
      n_fail++;
      $display("FAIL rst_async_clear: got %b expected all zero",
               {lsb_dout_valid, lsb_busy, lsb_dout, lsb_dout_first, lsb_dout_last, lsb_din_ready});
    end
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({lsb_din_ready, lsb_dout_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_release_ready: got ready/valid %b expected 10", {lsb_din_ready, lsb_dout_valid});
    end
    lsb_din = 16'hABCD; lsb_din_valid = 1'b1;
    step();
    lsb_din_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if ({lsb_dout_valid, lsb_dout, lsb_dout_first, lsb_dout_last} !==
          {1'b1, exp_beats[i], (i == 0), (i == 3)}) begin
        n_fail++;
        $display("FAIL rst_next_beat%0d: got v/d/f/l %b expected %b", i,
                 {lsb_dout_valid, lsb_dout, lsb_dout_first, lsb_dout_last},
                 {1'b1, exp_beats[i], (i == 0), (i == 3)});
      end
      step();
    end
  endtask

  task automatic test_single_beat();
    logic [7:0] words [3];
    int         acc, n, gaps;
    bit         will;
    words = '{8'h5A, 8'hC3, 8'h7E};
    acc = 0; n = 0; gaps = 0;
    byt_dout_ready = 1'b1;
    byt_din = words[0]; byt_din_valid = 1'b1;
    for (int cyc = 0; cyc < 30 && n < 3; cyc++) begin
      if (byt_dout_valid) begin
        n_checks++;
        if ({byt_dout, byt_dout_first, byt_dout_last} !== {words[n], 2'b11}) begin
          n_fail++;
          $display("FAIL single_word%0d: got d/f/l %b expected %b", n,
                   {byt_dout, byt_dout_first, byt_dout_last}, {words[n], 2'b11});
        end
        n++;
      end else if (n > 0) begin
        gaps++;
      end
      will = byt_din_valid & byt_din_ready;
      step();
      if (will) begin
        acc++;
        if (acc < 3) byt_din = words[acc];
        else         byt_din_valid = 1'b0;
      end
    end
    byt_din_valid = 1'b0;
    n_checks++;
    if (n != 3) begin
      n_fail++;
      $display("FAIL single_count: got %0d words expected 3", n);
    end
    n_checks++;
    if (gaps != (PF ? 0 : 2)) begin
      n_fail++;
      $display("FAIL single_gaps: got %0d expected %0d", gaps, (PF ? 0 : 2));
    end
  endtask

  initial begin
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_backpressure();
    test_back_to_back();
    test_mid_word_reset();
    test_single_beat();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/piso_stream_serializer.md
# piso_stream_serializer

Parametrised parallel-in/serial-out serializer that accepts DATA_WIDTH-bit words over a valid/ready handshake and emits them as LANES-bit beats, LSB-first or MSB-first, with downstream backpressure and frame markers. It sits between word-oriented datapaths and narrow serial links. It is the successor to the single-bit, handshake-less shift register: it adds multi-bit lanes, a bit-order mode, flow control in both directions, and optional gapless back-to-back streaming.

## Interface
- DATA_WIDTH, 16, input word width; must be a multiple of LANES.
- LANES, 1, bits emitted per beat; 1 ≤ LANES ≤ DATA_WIDTH.
- MSB_FIRST, 0, 0 = least-significant lane first (shift right); 1 = most-significant lane first (shift left).
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- din  input  DATA_WIDTH  parallel word.
- din_valid  input  1  din is valid.
- din_ready  output  1  block can accept a word this cycle.
- dout  output  LANES  current beat.
- dout_valid  output  1  dout is valid.
- dout_ready  input  1  downstream consumes the beat this cycle.
- dout_first  output  1  current beat is beat 0 of a word.
- dout_last  output  1  current beat is beat BEATS-1 of a word.
- busy  output  1  a word is being shifted or is held (includes prefetch).

## Operation
- BEATS = DATA_WIDTH/LANES. Beat counter width = max(1, clog2(BEATS)).
- Handshakes: accept on din_valid & din_ready at the edge; a beat retires on dout_valid & dout_ready at the edge.
- States: IDLE (no word loaded, dout_valid=0) and SHIFT (word loaded, dout_valid=1).
- IDLE → SHIFT on accept: load din into the shift register, beat counter = 0.
- In SHIFT, on retire with counter < BEATS-1: shift by LANES bits (zero fill), counter+1.
- In SHIFT, on retire with counter = BEATS-1: the word is done. The next step depends on the configuration; see Configuration.
- dout = shift_reg[LANES-1:0] when MSB_FIRST=0, or shift_reg[DATA_WIDTH-1 -: LANES] when MSB_FIRST=1.
- dout_first = dout_valid & (counter==0). dout_last = dout_valid & (counter==BEATS-1).
- When BEATS=1, dout_first and dout_last are both asserted on the single beat.
- When dout_ready=0, dout, dout_first, dout_last and the counter hold.
- dout_valid never drops mid-word.
- Values on din when no accept occurs are ignored.
- Reset asserted at any time, including mid-word: the partial word and the held word are discarded and the block goes to IDLE immediately.
- Reset values: dout=0, dout_valid=0, dout_first=0, dout_last=0, busy=0, din_ready=0 while reset is asserted.

## Timing
- Latency: a word accepted at edge N presents beat 0 in the cycle after edge N.
- Throughput with continuous dout_ready: one beat per cycle within a word.
- din_ready is combinational from state only, never from din_valid.
- dout_* are registered and have no combinational path from din_valid.
- Without the feature, din_ready = (state==IDLE).
- Without the feature, the last beat retiring at edge M gives IDLE with din_ready=1 in cycle M+1. The earliest next beat 0 is in cycle M+2, so there is exactly one bubble between words.

## Configuration
- PISO_PREFETCH_EN defined: a one-word holding register is added and din_ready = ~hold_valid.
  - An accept while in SHIFT fills the hold register.
  - When the last beat retires with hold_valid=1: load the held word into the shift register, counter=0, hold_valid=0, dout_valid stays 1. There is zero bubble.
  - When the last beat retires with hold empty and an accept at the same edge: load din directly into the shift register, with no bubble.
  - busy = (state==SHIFT) | hold_valid.
- PISO_PREFETCH_EN undefined: no holding register, with the one-bubble behaviour given under Timing. busy = (state==SHIFT).

## Structure
- Shared package piso_pkg:
  - the state enum {IDLE, SHIFT};
  - a function beats(DATA_WIDTH, LANES);
  - a function cnt_width(beats).
- Parameter legality checks (divisibility, lane range) are elaboration-time assertions in the top module.
- One sub-module, piso_hold_reg: a one-entry valid/data holding register with load/take ports. It is instantiated only under PISO_PREFETCH_EN.

## Test plan
- DATA_WIDTH=16, LANES=4, MSB_FIRST=0, dout_ready=1, din=16'hA5C3 → dout 3,C,5,A on consecutive cycles; dout_first on 3, dout_last on A.
- Same word with MSB_FIRST=1 → dout A,5,C,3; dout_first on A, dout_last on 3.
- Backpressure: dout_ready toggles 1,0,0,1,… on din=16'h1234, LANES=4 → each beat holds stably while stalled, no beat is lost or duplicated, order is 4,3,2,1.
- Back-to-back: din_valid held high with 16'h0001 then 16'h8000, LANES=1 → without PISO_PREFETCH_EN, one dout_valid=0 cycle between words; with it, 32 contiguous valid beats and din_ready drops only while the hold register is full.
- Reset pulse asserted mid-word, after beat 2 → dout_valid, busy and dout go to 0 with no clock edge needed. After release, din_ready=1 and the next word starts at beat 0.
- LANES=DATA_WIDTH=8, din=8'h5A → a single beat 5A with dout_first=dout_last=1; with the prefetch feature, consecutive words stream at one word per cycle.
